// File: rtl/iq_sync_checker_pkg.sv
// iq_sync_checker_pkg: shared sync constants, state encoding and I/Q field layout
package iq_sync_checker_pkg;
  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;
  localparam int I_SYNC_HI = 31;
  localparam int I_SYNC_LO = 30;
  localparam int Q_SYNC_HI = 15;
  localparam int Q_SYNC_LO = 14;
  localparam int I_HI = 29;
  localparam int I_LO = 17;
  localparam int Q_HI = 13;
  localparam int Q_LO = 1;
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2, SUSPECT = 2'd3} state_e;
  function automatic logic [15:0] sext16(input logic [12:0] x);
    return {{3{x[12]}}, x};
  endfunction
endpackage

// File: rtl/iq_sync_checker_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_b,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  // clear wins over increment; hold at all-ones instead of wrapping
  always_ff @(posedge i_clk)
    if (!i_rst_b || i_clear) o_count <= '0;
    else if (i_inc && !(&o_count)) o_count <= o_count + W'(1);
endmodule

// File: rtl/iq_sync_checker.sv
// iq_sync_checker: I/Q sync-bit lock tracker and aligned sample forwarder (optional bit-slip via IQ_SYNC_SLIP_EN)
module iq_sync_checker
  import iq_sync_checker_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_b,
  input  logic                 i_enable,
  input  logic [31:0]          i_data,
  input  logic                 i_clear,
  output logic                 o_valid,
  output logic [31:0]          o_data,
  output logic                 o_locked,
  output logic                 o_lock_lost,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic                 o_slip
);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic [3:0] UC = 4'(UNLOCK_COUNT);
  state_e state, state_n;
  logic [3:0] run, run_n, run_inc;
  logic en, sync_ok, good, bad, fwd, drop, err_inc;
  assign sync_ok = i_data[I_SYNC_HI:I_SYNC_LO] == I_SYNC && i_data[Q_SYNC_HI:Q_SYNC_LO] == Q_SYNC;
  assign good = en && sync_ok;
  assign bad = en && !sync_ok;
  assign run_inc = run + 4'd1;
  assign err_inc = bad && (state == LOCKED || state == SUSPECT);
`ifdef IQ_SYNC_SLIP_EN
  logic [1:0] holdoff;
  logic slip_req;
  assign en = i_enable && holdoff == 2'd0;
  assign slip_req = bad && state == HUNT;
  // one-cycle slip pulse, then swallow the next three words while lvds_rx realigns
  always_ff @(posedge i_clk)
    if (!i_rst_b) begin
      o_slip <= 1'b0;
      holdoff <= 2'd0;
    end else begin
      o_slip <= slip_req;
      holdoff <= slip_req ? 2'd3 : state_n != HUNT ? 2'd0 : (i_enable && holdoff != 2'd0) ? holdoff - 2'd1 : holdoff;
    end
`else
  assign en = i_enable;
  assign o_slip = 1'b0;
`endif
  // lock hysteresis: next state, run counter, forward and drop decisions
  always_comb begin
    state_n = state;
    run_n = run;
    fwd = 1'b0;
    drop = 1'b0;
    case (state)
      HUNT: if (good) begin
        state_n = LC == 4'd1 ? LOCKED : VERIFY;
        run_n = LC == 4'd1 ? 4'd0 : 4'd1;
        fwd = LC == 4'd1;
      end
      VERIFY: if (good) begin
        state_n = run_inc == LC ? LOCKED : VERIFY;
        run_n = run_inc == LC ? 4'd0 : run_inc;
        fwd = run_inc == LC;
      end else if (bad) begin
        state_n = HUNT;
        run_n = 4'd0;
      end
      LOCKED: begin
        fwd = good;
        if (bad) begin
          state_n = UC == 4'd1 ? HUNT : SUSPECT;
          run_n = UC == 4'd1 ? 4'd0 : 4'd1;
          drop = UC == 4'd1;
        end
      end
      SUSPECT: begin
        fwd = good;
        if (good) begin
          state_n = LOCKED;
          run_n = 4'd0;
        end else if (bad) begin
          state_n = run_inc == UC ? HUNT : SUSPECT;
          run_n = run_inc == UC ? 4'd0 : run_inc;
          drop = run_inc == UC;
        end
      end
    endcase
  end
  // state, registered outputs and sticky lock-lost flag
  always_ff @(posedge i_clk)
    if (!i_rst_b) begin
      state <= HUNT;
      run <= 4'd0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_locked <= 1'b0;
      o_lock_lost <= 1'b0;
    end else begin
      state <= state_n;
      run <= run_n;
      o_valid <= fwd;
      o_data <= fwd ? {sext16(i_data[I_HI:I_LO]), sext16(i_data[Q_HI:Q_LO])} : o_data;
      o_locked <= state_n == LOCKED || state_n == SUSPECT;
      o_lock_lost <= i_clear ? 1'b0 : (drop || o_lock_lost);
    end
  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_b (i_rst_b),
    .i_clear (i_clear),
    .i_inc   (err_inc),
    .o_count (o_err_count)
  );
endmodule

// File: tb/tb_iq_sync_checker.sv
// tb_iq_sync_checker: directed vector table plus hand sequences for saturation, clear priority and reset
module tb_iq_sync_checker;
  localparam logic [31:0] G = 32'h8002_4002;
  localparam logic [31:0] B = 32'h0000_0000;
  localparam logic [31:0] S = 32'hBFFF_7FFF;
  localparam logic [31:0] D1 = 32'h0001_0001;
  localparam logic [31:0] DM = 32'hFFFF_FFFF;
  typedef struct {
    logic        en;
    logic [31:0] data;
    logic        clr;
    logic        rst_b;
    logic        v;
    logic [31:0] d;
    logic        lk;
    logic        lost;
    logic [3:0]  err;
  } vec_t;
  logic clk = 1'b0;
  logic i_rst_b = 1'b0;
  logic i_enable = 1'b0;
  logic [31:0] i_data = '0;
  logic i_clear = 1'b0;
  logic o_valid, o_locked, o_lock_lost, o_slip;
  logic [31:0] o_data;
  logic [3:0] o_err_count;
  int checks = 0;
  int errors = 0;
  vec_t vq[$];
  always #5 clk = ~clk;
  iq_sync_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(2), .ERR_CNT_W(4)) dut (
    .i_clk       (clk),
    .i_rst_b     (i_rst_b),
    .i_enable    (i_enable),
    .i_data      (i_data),
    .i_clear     (i_clear),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_locked    (o_locked),
    .o_lock_lost (o_lock_lost),
    .o_err_count (o_err_count),
    .o_slip      (o_slip)
  );
  function automatic vec_t mk(logic en, logic [31:0] data, logic clr, logic rb, logic v, logic [31:0] d, logic lk, logic lost, logic [3:0] err);
    vec_t t;
    t.en = en; t.data = data; t.clr = clr; t.rst_b = rb;
    t.v = v; t.d = d; t.lk = lk; t.lost = lost; t.err = err;
    return t;
  endfunction
  task automatic step(input vec_t t, input string name);
    i_enable = t.en;
    i_data = t.data;
    i_clear = t.clr;
    i_rst_b = t.rst_b;
    @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_data, o_locked, o_lock_lost, o_err_count, o_slip} !== {t.v, t.d, t.lk, t.lost, t.err, 1'b0}) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h lk=%b lost=%b err=%h slip=%b, want v=%b d=%h lk=%b lost=%b err=%h slip=0",
               name, o_valid, o_data, o_locked, o_lock_lost, o_err_count, o_slip, t.v, t.d, t.lk, t.lost, t.err);
    end
    i_enable = 1'b0;
    i_clear = 1'b0;
    i_rst_b = 1'b1;
  endtask
  initial begin
    vq.push_back(mk(0, B, 0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(1, G, 0, 1, 0, 0,  0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      vq.push_back(mk(0, G, 0, 1, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, G, 0, 1, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, G, 0, 1, 0, 0, 0, 0, 0));
      vq.push_back(mk(1, G, 0, 1, k == 2, k == 2 ? D1 : 32'h0, k == 2, 0, 0));
    end
    vq.push_back(mk(0, G, 0, 1, 0, D1, 1, 0, 0));
    vq.push_back(mk(1, S, 0, 1, 1, DM, 1, 0, 0));
    vq.push_back(mk(1, G, 0, 1, 1, D1, 1, 0, 0));
    vq.push_back(mk(1, B, 0, 1, 0, D1, 1, 0, 1));
    vq.push_back(mk(1, G, 0, 1, 1, D1, 1, 0, 1));
    vq.push_back(mk(1, B, 0, 1, 0, D1, 1, 0, 2));
    vq.push_back(mk(1, B, 0, 1, 0, D1, 0, 1, 3));
    vq.push_back(mk(1, S, 0, 1, 0, D1, 0, 1, 3));
    vq.push_back(mk(0, B, 1, 1, 0, D1, 0, 0, 0));
    vq.push_back(mk(1, G, 0, 1, 0, D1, 0, 0, 0));
    vq.push_back(mk(1, G, 0, 1, 0, D1, 0, 0, 0));
    vq.push_back(mk(1, G, 0, 1, 1, D1, 1, 0, 0));
    vq.push_back(mk(0, B, 0, 1, 0, D1, 1, 0, 0));
    foreach (vq[i]) step(vq[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++) begin
      step(mk(1, B, 0, 1, 0, D1, 1, 0, (i + 1 > 15) ? 4'hF : 4'(i + 1)), $sformatf("sat_bad%0d", i));
      step(mk(1, G, 0, 1, 1, D1, 1, 0, (i + 1 > 15) ? 4'hF : 4'(i + 1)), $sformatf("sat_good%0d", i));
    end
    step(mk(1, B, 0, 1, 0, D1, 1, 0, 4'hF), "sat_suspect");
    step(mk(1, B, 0, 1, 0, D1, 0, 1, 4'hF), "sat_drop");
    for (int i = 0; i < 4; i++) step(mk(1, G, 0, 1, i == 3, D1, i == 3, 1, 4'hF), $sformatf("relock%0d", i));
    step(mk(1, B, 1, 1, 0, D1, 1, 0, 0), "clr_bad");
    step(mk(1, B, 1, 1, 0, D1, 0, 0, 0), "clr_drop");
    for (int i = 0; i < 4; i++) step(mk(1, S, 0, 1, i == 3, i == 3 ? DM : D1, i == 3, 0, 0), $sformatf("lock_b%0d", i));
    step(mk(1, G, 0, 1, 1, D1, 1, 0, 0), "pre_rst");
    step(mk(1, G, 0, 0, 0, 0, 0, 0, 0), "rst_mid");
    for (int i = 0; i < 4; i++) step(mk(1, G, 0, 1, i == 3, i == 3 ? D1 : 32'h0, i == 3, 0, 0), $sformatf("post_rst%0d", i));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
